bcd_timer_chain: RTL and testbench

- Parametrised, fully synchronous chain of BCD digit counters with per-digit modulus, up/down mode, parallel load and a run/pause/done control FSM.
- Successor to the per-digit JK ripple counters in the clock datapath. A single `clk` replaces the ripple clocks, and each digit advances on a `tick` enable.
- Default configuration is an mm:ss timer/stopwatch (59:59 max) feeding the 7-segment display decoders.

---
 rtl/bcd_timer_chain.sv | 132 +++++++++++++
 tb/tb_bcd_timer_chain.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_timer_chain.sv
// Synchronous BCD digit-counter chain with per-digit modulus, up/down count,
// parallel load and an IDLE/RUN/PAUSE/DONE control FSM. Optional alarm: BCD_TIMER_ALARM_EN.
module bcd_timer_chain #(
  parameter int                  DIGITS = 4,
  parameter logic [4*DIGITS-1:0] MODULI = 16'h6A6A
) (
  input  logic                  clk,
  input  logic                  clear,
  input  logic                  tick,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_value,
  input  logic                  dir,
`ifdef BCD_TIMER_ALARM_EN
  input  logic [4*DIGITS-1:0]   alarm_value,
  output logic                  alarm,
`endif
  output logic [4*DIGITS-1:0]   count,
  output logic                  carry_out,
  output logic                  running,
  output logic                  done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

  state_t                r_state;
  logic [4*DIGITS-1:0]   r_count;
  logic                  r_carry;
  logic                  r_running;
  logic                  r_done;

  logic [DIGITS:0]       w_carry;
  logic [DIGITS-1:0]     w_borrow;
  logic [4*DIGITS-1:0]   w_up_next;
  logic [4*DIGITS-1:0]   w_dn_next;
  logic [4*DIGITS-1:0]   w_sat;
  logic [4*DIGITS-1:0]   w_tick_next;
  logic                  w_dn_zero;
  logic                  w_count_zero;

  assign w_carry[0]  = 1'b1;
  assign w_borrow[0] = 1'b1;

  // Carry and borrow ripple combinationally so a full wrap settles in one edge.
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    localparam logic [3:0] MOD  = MODULI[4*gi +: 4];
    localparam logic [3:0] MAXD = MOD - 4'd1;
    logic [3:0] w_digit;
    logic [3:0] w_load_nib;
    logic       w_max;
    logic       w_zero;

    assign w_digit    = r_count[4*gi +: 4];
    assign w_load_nib = load_value[4*gi +: 4];
    assign w_max      = (w_digit == MAXD);
    assign w_zero     = (w_digit == 4'd0);

    assign w_up_next[4*gi +: 4] = w_carry[gi]  ? (w_max  ? 4'd0 : w_digit + 4'd1) : w_digit;
    assign w_dn_next[4*gi +: 4] = w_borrow[gi] ? (w_zero ? MAXD : w_digit - 4'd1) : w_digit;
    assign w_carry[gi+1]        = w_carry[gi] & w_max;
    if (gi < DIGITS-1) begin : g_borrow
      assign w_borrow[gi+1] = w_borrow[gi] & w_zero;
    end

    assign w_sat[4*gi +: 4] = (w_load_nib >= MOD) ? MAXD : w_load_nib;
  end

  assign w_dn_zero    = (w_dn_next == '0);
  assign w_count_zero = (r_count == '0);
  assign w_tick_next  = dir ? w_up_next : w_dn_next;

`ifdef BCD_TIMER_ALARM_EN
  logic r_alarm;
  assign alarm = r_alarm;
`endif

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      r_state   <= S_IDLE;
      r_count   <= '0;
      r_carry   <= 1'b0;
      r_running <= 1'b0;
      r_done    <= 1'b0;
`ifdef BCD_TIMER_ALARM_EN
      r_alarm   <= 1'b0;
`endif
    end else begin
      r_carry <= 1'b0;
`ifdef BCD_TIMER_ALARM_EN
      r_alarm <= 1'b0;
`endif
      if (r_state == S_RUN) begin
        if (stop) begin
          r_state   <= S_PAUSE;
          r_running <= 1'b0;
        end else if (tick) begin
          r_count <= w_tick_next;
          r_carry <= dir & w_carry[DIGITS];
`ifdef BCD_TIMER_ALARM_EN
          r_alarm <= (w_tick_next == alarm_value);
`endif
          if (!dir && w_dn_zero) begin
            r_state   <= S_DONE;
            r_running <= 1'b0;
            r_done    <= 1'b1;
          end
        end
      end else if (load) begin
        r_count   <= w_sat;
        r_state   <= S_IDLE;
        r_running <= 1'b0;
        r_done    <= 1'b0;
      end else if (!stop && start && r_state != S_DONE) begin
        // Starting a countdown from zero has nothing to count.
        if (r_state == S_IDLE && !dir && w_count_zero) begin
          r_state <= S_DONE;
          r_done  <= 1'b1;
        end else begin
          r_state   <= S_RUN;
          r_running <= 1'b1;
        end
      end
    end
  end

  assign count     = r_count;
  assign carry_out = r_carry;
  assign running   = r_running;
  assign done      = r_done;

endmodule

// File: tb/tb_bcd_timer_chain.sv
// Bench for bcd_timer_chain: integer-valued mm:ss model checked every cycle,
// plus directed literal checks and a randomized command phase.
module tb_bcd_timer_chain;
  localparam int TOTAL = 3600;

  logic        clk = 1'b0;
  logic        clear = 1'b1;
  logic        tick = 1'b0, start = 1'b0, stop = 1'b0, load = 1'b0, dir = 1'b1;
  logic [15:0] load_value = '0;
  logic [15:0] alarm_value = 16'hFFFF;
  logic [15:0] count;
  logic        carry_out, running, done;
  logic        alarm;

  int checks = 0;
  int errors = 0;

  int md[4] = '{10, 6, 10, 6};

  // Model: 0 idle, 1 run, 2 pause, 3 done; count held as seconds 0..3599.
  int   m_state = 0;
  int   m_val   = 0;
  logic m_carry = 1'b0;
  logic m_alarm = 1'b0;

  always #5 clk = ~clk;

  bcd_timer_chain dut (
    .clk        (clk),
    .clear      (clear),
    .tick       (tick),
    .start      (start),
    .stop       (stop),
    .load       (load),
    .load_value (load_value),
    .dir        (dir),
`ifdef BCD_TIMER_ALARM_EN
    .alarm_value(alarm_value),
    .alarm      (alarm),
`endif
    .count      (count),
    .carry_out  (carry_out),
    .running    (running),
    .done       (done)
  );
`ifndef BCD_TIMER_ALARM_EN
  assign alarm = 1'b0;
`endif

  function automatic int to_val(input logic [15:0] b);
    int v = 0;
    int w = 1;
    for (int i = 0; i < 4; i++) begin
      v = v + int'(b[4*i +: 4]) * w;
      w = w * md[i];
    end
    return v;
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] b = '0;
    int r = v;
    for (int i = 0; i < 4; i++) begin
      b[4*i +: 4] = 4'(r % md[i]);
      r = r / md[i];
    end
    return b;
  endfunction

  function automatic logic [15:0] saturate(input logic [15:0] b);
    logic [15:0] s = b;
    for (int i = 0; i < 4; i++)
      if (int'(b[4*i +: 4]) >= md[i]) s[4*i +: 4] = 4'(md[i] - 1);
    return s;
  endfunction

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_val = 0; m_carry = 1'b0; m_alarm = 1'b0;
  endtask

  task automatic model_step();
    int s = m_state;
    m_carry = 1'b0;
    m_alarm = 1'b0;
    if (s == 1) begin
      if (stop) m_state = 2;
      else if (tick) begin
        if (dir) begin
          m_carry = (m_val == TOTAL - 1);
          m_val   = (m_val + 1) % TOTAL;
        end else begin
          m_val = (m_val + TOTAL - 1) % TOTAL;
          if (m_val == 0) m_state = 3;
        end
        m_alarm = (to_bcd(m_val) == alarm_value);
      end
    end else if (load) begin
      m_val = to_val(saturate(load_value));
      m_state = 0;
    end else if (!stop && start && s != 3) begin
      m_state = (s == 0 && !dir && m_val == 0) ? 3 : 1;
    end
  endtask

  always @(posedge clear) model_reset();

  always @(posedge clk) begin
    if (clear) model_reset();
    else model_step();
    #1;
    chk("model_count", count, to_bcd(m_val));
    chk("model_carry", {15'd0, carry_out}, {15'd0, m_carry});
    chk("model_running", {15'd0, running}, {15'd0, m_state == 1});
    chk("model_done", {15'd0, done}, {15'd0, m_state == 3});
`ifdef BCD_TIMER_ALARM_EN
    chk("model_alarm", {15'd0, alarm}, {15'd0, m_alarm});
`endif
  end

  task automatic cyc(input logic tk, input logic st, input logic sp,
                     input logic ld, input logic [15:0] lv);
    @(negedge clk);
    tick = tk; start = st; stop = sp; load = ld; load_value = lv;
    @(posedge clk);
    #2;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    clear = 1'b0;
    #1;
    chk("reset_count", count, 16'h0000);
    chk("reset_flags", {13'd0, carry_out, running, done}, 16'h0000);

    // Up wrap from 59:58.
    dir = 1'b1;
    cyc(0, 0, 0, 1, 16'h5958); chk("load_5958", count, 16'h5958);
    cyc(0, 1, 0, 0, 16'h0);    chk("start_run", {15'd0, running}, 16'h1);
    cyc(1, 0, 0, 0, 16'h0);    chk("up_5959", count, 16'h5959);
    cyc(1, 0, 0, 0, 16'h0);    chk("wrap_0000", count, 16'h0000);
    chk("wrap_carry", {15'd0, carry_out}, 16'h1);
    chk("wrap_running", {15'd0, running}, 16'h1);
    cyc(0, 0, 0, 0, 16'h0);    chk("carry_pulse_end", {15'd0, carry_out}, 16'h0);

    // Down count with borrows.
    cyc(0, 0, 1, 0, 16'h0);
    cyc(0, 0, 0, 1, 16'h0110);
    dir = 1'b0;
    cyc(0, 1, 0, 0, 16'h0);
    cyc(1, 0, 0, 0, 16'h0);    chk("down_0109", count, 16'h0109);
    cyc(1, 0, 0, 0, 16'h0);    chk("down_0108", count, 16'h0108);
    cyc(0, 0, 1, 0, 16'h0);
    cyc(0, 0, 0, 1, 16'h0100);
    cyc(0, 1, 0, 0, 16'h0);
    cyc(1, 0, 0, 0, 16'h0);    chk("down_0059", count, 16'h0059);

    // Countdown to zero.
    cyc(0, 0, 1, 0, 16'h0);
    cyc(0, 0, 0, 1, 16'h0001);
    cyc(0, 1, 0, 0, 16'h0);
    cyc(1, 0, 0, 0, 16'h0);    chk("done_count", count, 16'h0000);
    chk("done_flags", {14'd0, running, done}, 16'h0001);
    cyc(1, 1, 0, 0, 16'h0);    chk("done_hold", {count[14:0], done}, 16'h0001);
    cyc(0, 0, 0, 1, 16'h0030); chk("load_from_done", count, 16'h0030);
    chk("done_cleared", {15'd0, done}, 16'h0);

    // Per-digit saturation: 7,F,B,9 -> 5,9,5,9.
    cyc(0, 0, 0, 1, 16'h7FB9); chk("saturate", count, 16'h5959);

    // Stop/start coincident with tick.
    dir = 1'b1;
    cyc(0, 0, 0, 1, 16'h0010);
    cyc(0, 1, 0, 0, 16'h0);
    cyc(1, 0, 1, 0, 16'h0);    chk("stop_tick_cnt", count, 16'h0010);
    chk("stop_tick_run", {15'd0, running}, 16'h0);
    cyc(1, 1, 0, 0, 16'h0);    chk("start_tick_cnt", count, 16'h0010);
    chk("start_tick_run", {15'd0, running}, 16'h1);
    cyc(1, 0, 0, 0, 16'h0);    chk("after_start_0011", count, 16'h0011);

    // Asynchronous clear between edges.
    cyc(1, 0, 0, 0, 16'h0);
    #1 clear = 1'b1;
    #1;
    chk("async_clear_count", count, 16'h0000);
    chk("async_clear_flags", {14'd0, running, done}, 16'h0000);
    @(negedge clk);
    tick = 1'b0;
    @(negedge clk);
    clear = 1'b0;

`ifdef BCD_TIMER_ALARM_EN
    alarm_value = 16'h0003;
    cyc(0, 1, 0, 0, 16'h0);
    cyc(1, 0, 0, 0, 16'h0);    chk("alarm_t1", {15'd0, alarm}, 16'h0);
    cyc(1, 0, 0, 0, 16'h0);    chk("alarm_t2", {15'd0, alarm}, 16'h0);
    cyc(1, 0, 0, 0, 16'h0);    chk("alarm_t3", {15'd0, alarm}, 16'h1);
    cyc(0, 0, 0, 0, 16'h0);    chk("alarm_end", {15'd0, alarm}, 16'h0);
    cyc(1, 0, 0, 0, 16'h0);    chk("alarm_t4", {15'd0, alarm}, 16'h0);
`endif

    // Randomized commands against the model.
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      if ($urandom_range(0, 7) == 0) dir = 1'($urandom);
      if ($urandom_range(0, 31) == 0) alarm_value = to_bcd((m_val + $urandom_range(1, 4)) % TOTAL);
      tick       = ($urandom_range(0, 1) == 0);
      start      = ($urandom_range(0, 7) == 0);
      stop       = ($urandom_range(0, 15) == 0);
      load       = ($urandom_range(0, 15) == 0);
      load_value = ($urandom_range(0, 3) == 0) ? 16'($urandom) : to_bcd($urandom_range(0, 20));
      clear      = ($urandom_range(0, 299) == 0);
    end
    @(negedge clk);
    tick = 0; start = 0; stop = 0; load = 0; clear = 0;
    repeat (3) @(posedge clk);
    #3;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
